scoreboard_ctrl: RTL and testbench

//  Register scoreboard for the in-order-issue, out-of-order-completion pipe. Per architectural

---
 rtl/scoreboard_ctrl_pkg.sv | 26 ++
 rtl/scoreboard_wb_pipe.sv | 57 +++++
 rtl/scoreboard_ctrl.sv | 104 ++++++++++
 tb/tb_scoreboard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_ctrl_pkg.sv
// Shared scoreboard constants and the writeback reservation slot type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// SB_RD_* name the lookup port order used by the hazard detector.
package scoreboard_ctrl_pkg;

  localparam int SB_ROW_W    = 5;
  localparam int SB_MAX_LAT  = 31;   // 2**SB_ROW_W - 1
  localparam int SB_NUM_REGS = 32;
  localparam int SB_ADDR_W   = 5;
  localparam int SB_NUM_RD   = 5;

  localparam int SB_RD_ISS_A  = 0;
  localparam int SB_RD_ISS_B  = 1;
  localparam int SB_RD_ID_A   = 2;
  localparam int SB_RD_ID_B   = 3;
  localparam int SB_RD_ID_WAW = 4;

  // One writeback reservation: the register that retires when this slot reaches slot 0.
  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
  } wb_slot_t;

endpackage

// File: rtl/scoreboard_wb_pipe.sv
// Writeback-port reservation pipe: slot i retires i cycles from now; slot 0 drives the wb outputs.
// Latency: a load with latency L appears on wb_valid/wb_waddr L cycles after it is presented.
// Backpressure: none; a load always lands, overwriting whatever the shift would have placed there.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   load, load_lat     reserve slot load_lat-1 (load_lat must be nonzero when load is high)
//   load_addr          register recorded in the reserved slot
//   wb_valid, wb_waddr registered slot 0 contents
//   occupancy          valid bit of every slot, for the hazard column
module scoreboard_wb_pipe
  import scoreboard_ctrl_pkg::*;
#(
  parameter int MAX_LAT = SB_MAX_LAT,
  parameter int ROW_W   = SB_ROW_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROW_W-1:0]     load_lat,
  input  logic [SB_ADDR_W-1:0] load_addr,
  output logic                 wb_valid,
  output logic [SB_ADDR_W-1:0] wb_waddr,
  output logic [MAX_LAT:0]     occupancy
);

  wb_slot_t         slot [MAX_LAT+1];
  logic [ROW_W-1:0] load_idx;

  // The slot is filled one cycle after issue, so a latency-L result sits at L-1 then.
  assign load_idx = load_lat - ROW_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= MAX_LAT; i++) begin
        slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < MAX_LAT; i++) begin
        slot[i] <= slot[i+1];
      end
      slot[MAX_LAT] <= '0;
      // Later assignment wins over the shift for the reserved slot.
      if (load) begin
        slot[load_idx] <= '{valid: 1'b1, addr: load_addr};
      end
    end
  end

  assign wb_valid = slot[0].valid;
  assign wb_waddr = slot[0].addr;

  for (genvar g = 0; g <= MAX_LAT; g++) begin : g_occ
    assign occupancy[g] = slot[g].valid;
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// Register scoreboard: per-register pending bit and row countdown, lookup ports, writeback hazard column.
// Latency: lookups and haz_column are combinational from state; an issue updates state next cycle.
// Backpressure: none; the hazard detector stalls Issue, this block accepts every fired write.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   iss_fire/iss_writereg/iss_waddr/iss_latency   issuing instruction
//   rd_addr -> rd_pending, rd_row   NUM_RD lookups, port k at rd_addr[5k+4:5k]
//   haz_column                      writeback slot conflict for iss_latency
//   wb_valid, wb_waddr              register written back this cycle
module scoreboard_ctrl
  import scoreboard_ctrl_pkg::*;
#(
  parameter int NUM_RD  = SB_NUM_RD,
  parameter int MAX_LAT = SB_MAX_LAT,
  parameter int ROW_W   = SB_ROW_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          iss_fire,
  input  logic                          iss_writereg,
  input  logic [SB_ADDR_W-1:0]          iss_waddr,
  input  logic [ROW_W-1:0]              iss_latency,
  input  logic [NUM_RD*SB_ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD-1:0]             rd_pending,
  output logic [NUM_RD*ROW_W-1:0]       rd_row,
  output logic [SB_NUM_REGS-1:0]        haz_column,
  output logic                          wb_valid,
  output logic [SB_ADDR_W-1:0]          wb_waddr
);

  logic [SB_NUM_REGS-1:0] pend;
  logic [ROW_W-1:0]       row [SB_NUM_REGS];
  logic [MAX_LAT:0]       occupancy;
  logic                   wr_accept;

  // Latencies above MAX_LAT cannot be encoded in ROW_W bits, so nonzero is the full legality test.
  assign wr_accept = iss_fire && iss_writereg && (iss_waddr != '0) && (iss_latency != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
      for (int r = 0; r < SB_NUM_REGS; r++) begin
        row[r] <= '0;
      end
    end else begin
      for (int r = 0; r < SB_NUM_REGS; r++) begin
        // A new load beats a same-cycle expiry, so the register stays pending.
        if (wr_accept && (iss_waddr == SB_ADDR_W'(r))) begin
          pend[r] <= 1'b1;
          row[r]  <= iss_latency;
        end else if (row[r] != '0) begin
          row[r] <= row[r] - ROW_W'(1);
          if (row[r] == ROW_W'(1)) begin
            pend[r] <= 1'b0;
          end
        end
      end
    end
  end

  // Lookups see committed state only; same-cycle issue is handled by the hazard detector.
  always_comb begin
    rd_pending = '0;
    rd_row     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*SB_ADDR_W +: SB_ADDR_W] != '0) begin
        rd_pending[k]             = pend[rd_addr[k*SB_ADDR_W +: SB_ADDR_W]];
        rd_row[k*ROW_W +: ROW_W]  = row[rd_addr[k*SB_ADDR_W +: SB_ADDR_W]];
      end
    end
  end

  // Slot L now becomes slot L-1 next cycle, which is exactly where a latency-L issue would land.
  always_comb begin
    haz_column = '0;
    if (iss_writereg && (iss_latency != '0)) begin
      haz_column[iss_latency] = occupancy[iss_latency];
    end
  end

  scoreboard_wb_pipe #(
    .MAX_LAT (MAX_LAT),
    .ROW_W   (ROW_W)
  ) u_wb_pipe (
    .clk       (clk),
    .reset     (reset),
    .load      (wr_accept),
    .load_lat  (iss_latency),
    .load_addr (iss_waddr),
    .wb_valid  (wb_valid),
    .wb_waddr  (wb_waddr),
    .occupancy (occupancy)
  );

  // Illegal situations the hazard detector is expected to prevent.
  a_lat_legal: assert property (@(posedge clk) disable iff (reset)
    (iss_fire && iss_writereg) |-> (iss_latency != '0));
  a_no_waw: assert property (@(posedge clk) disable iff (reset)
    wr_accept |-> !(pend[iss_waddr] && (row[iss_waddr] != ROW_W'(1))));
  a_slot_free: assert property (@(posedge clk) disable iff (reset)
    wr_accept |-> !occupancy[iss_latency]);

endmodule

// File: tb/tb_scoreboard_ctrl.sv
module tb_scoreboard_ctrl;

  localparam int NUM_RD = 5;
  localparam int ROW_W  = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic                iss_fire;
  logic                iss_writereg;
  logic [4:0]          iss_waddr;
  logic [ROW_W-1:0]    iss_latency;
  logic [NUM_RD*5-1:0] rd_addr;
  logic [NUM_RD-1:0]   rd_pending;
  logic [NUM_RD*ROW_W-1:0] rd_row;
  logic [31:0]         haz_column;
  logic                wb_valid;
  logic [4:0]          wb_waddr;

  scoreboard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .iss_fire     (iss_fire),
    .iss_writereg (iss_writereg),
    .iss_waddr    (iss_waddr),
    .iss_latency  (iss_latency),
    .rd_addr      (rd_addr),
    .rd_pending   (rd_pending),
    .rd_row       (rd_row),
    .haz_column   (haz_column),
    .wb_valid     (wb_valid),
    .wb_waddr     (wb_waddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [4:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_check = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int due, input logic [4:0] addr);
    exp_t e;
    int   pos;
    e.due  = due;
    e.addr = addr;
    pos = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].due > due) begin
        pos = i;
        break;
      end
    end
    exp_q.insert(pos, e);
  endtask

  // Every cycle the writeback port must match the scoreboard exactly.
  task automatic check_wb();
    if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
      chk($sformatf("wb_valid@%0d", cyc), wb_valid, 1);
      chk($sformatf("wb_waddr@%0d", cyc), wb_waddr, exp_q[0].addr);
      void'(exp_q.pop_front());
    end else begin
      chk($sformatf("wb_idle_valid@%0d", cyc), wb_valid, 0);
      chk($sformatf("wb_idle_waddr@%0d", cyc), wb_waddr, 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_wb();
  endtask

  task automatic idle_inputs();
    iss_fire     = 1'b0;
    iss_writereg = 1'b0;
    iss_waddr    = '0;
    iss_latency  = '0;
  endtask

  task automatic drive_issue(input logic [4:0] a, input logic [ROW_W-1:0] l);
    iss_fire     = 1'b1;
    iss_writereg = 1'b1;
    iss_waddr    = a;
    iss_latency  = l;
    if (!reset && a != 0 && l != 0) push_exp(cyc + int'(l), a);
  endtask

  task automatic look(input logic [4:0] a, input logic [4:0] b);
    rd_addr        = '0;
    rd_addr[4:0]   = a;
    rd_addr[9:5]   = b;
    #1;
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] a, input logic p, input logic [ROW_W-1:0] r);
    look(a, 5'd0);
    chk({tag, "_pend"}, rd_pending[0], p);
    chk({tag, "_row"}, rd_row[ROW_W-1:0], r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rd_addr = '0;
    reset   = 1'b1;
    @(posedge clk); #1;
    // An issue presented during reset must be dropped.
    drive_issue(5'd9, 5'd2);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    exp_q.delete();
    cyc = 0;

    // Reset state on every port.
    rd_addr = {5'd31, 5'd9, 5'd5, 5'd1, 5'd0};
    #1;
    chk("rst_pending", rd_pending, 0);
    chk("rst_row", rd_row, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_waddr", wb_waddr, 0);
    chk("rst_haz", haz_column, 0);
    for (int i = 0; i < 3; i++) tick();
    chk_reg("rst_issue_drop_r9", 5'd9, 1'b0, 5'd0);

    // r5, latency 3.
    drive_issue(5'd5, 5'd3);
    tick();
    idle_inputs();
    chk_reg("r5_t1", 5'd5, 1'b1, 5'd3);
    tick();
    chk_reg("r5_t2", 5'd5, 1'b1, 5'd2);
    tick();
    chk_reg("r5_t3", 5'd5, 1'b1, 5'd1);
    tick();
    chk_reg("r5_t4", 5'd5, 1'b0, 5'd0);

    // r0 is never tracked and never reserves writeback.
    drive_issue(5'd0, 5'd2);
    tick();
    idle_inputs();
    chk_reg("r0_t1", 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) tick();

    // Hazard column.
    drive_issue(5'd3, 5'd4);
    tick();
    idle_inputs();
    iss_writereg = 1'b1;
    iss_latency  = 5'd3;
    #1;
    chk("haz_l3", haz_column, 32'h8);
    iss_latency = 5'd2;
    #1;
    chk("haz_l2", haz_column, 32'h0);
    iss_latency  = 5'd3;
    iss_writereg = 1'b0;
    #1;
    chk("haz_nowrite", haz_column, 32'h0);
    idle_inputs();
    for (int i = 0; i < 4; i++) tick();

    // Back-to-back latency-1 issues.
    drive_issue(5'd1, 5'd1);
    tick();
    drive_issue(5'd2, 5'd1);
    tick();
    idle_inputs();
    tick();
    look(5'd1, 5'd2);
    chk("b2b_pend", rd_pending[1:0], 2'b00);
    chk("b2b_row", rd_row[2*ROW_W-1:0], 0);

    // Reload on the expiry cycle keeps the register pending.
    drive_issue(5'd4, 5'd2);
    tick();
    idle_inputs();
    tick();
    chk_reg("reload_t2", 5'd4, 1'b1, 5'd1);
    drive_issue(5'd4, 5'd3);
    tick();
    idle_inputs();
    chk_reg("reload_t3", 5'd4, 1'b1, 5'd3);
    for (int i = 0; i < 3; i++) tick();
    chk_reg("reload_done", 5'd4, 1'b0, 5'd0);

    // Reset mid-flight clears pending and the reservation pipe.
    drive_issue(5'd7, 5'd5);
    tick();
    idle_inputs();
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    chk_reg("rst_mid_r7", 5'd7, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) tick();

    // Maximum latency.
    drive_issue(5'd31, 5'd31);
    tick();
    idle_inputs();
    iss_writereg = 1'b1;
    iss_latency  = 5'd30;
    #1;
    chk("haz_l30", haz_column, 32'h4000_0000);
    iss_latency = 5'd31;
    #1;
    chk("haz_l31", haz_column, 32'h0);
    idle_inputs();
    chk_reg("r31_t1", 5'd31, 1'b1, 5'd31);
    for (int i = 0; i < 30; i++) tick();
    chk_reg("r31_t31", 5'd31, 1'b1, 5'd1);
    tick();
    chk_reg("r31_t32", 5'd31, 1'b0, 5'd0);
    tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
